div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one iterative divider engine between NREQ requesters. It accepts one request per transaction over a valid/ready handshake and starts the engine with a one-cycle pulse. It waits for the engine's level done, captures the result, returns the engine to idle, and presents the result on a shared response bus tagged with the requester index. Divide-by-zero requests are answered locally and never reach the engine.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, dividend/divisor/quotient/remainder width
IDW, 2, requester index width; must equal clog2(NREQ)
TMO, 64, watchdog limit in cycles spent in WAIT (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_dividend  in  NREQ*W  packed dividends; requester i occupies bits [i*W +: W]
req_divisor  in  NREQ*W  packed divisors, same packing
req_ready  out  NREQ  one-hot acceptance pulse
div_start  out  1  one-cycle start pulse to the engine
div_dividend  out  W  operand to the engine, held from ISSUE through WAIT
div_divisor  out  W  operand to the engine, held from ISSUE through WAIT
div_clr  out  1  one-cycle pulse returning the engine to its init state
div_done  in  1  engine done; level, stays high until div_clr
div_quotient  in  W  engine result
div_remainder  in  W  engine result
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  IDW  index of the requester served
resp_quotient  out  W  result quotient
resp_remainder  out  W  result remainder
resp_err  out  1  1 = divide by zero
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; operand and result registers 0.
- Reset asserted mid-operation aborts the transaction. The in-flight result is discarded. On the cycle after reset deasserts, div_clr pulses once so the engine is forced to init; no other outputs change on that cycle.
- Arbitration, evaluated in IDLE only:
  - Search req_valid starting at the pointer and wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner] pulses for one cycle in IDLE; the winner's operands and index are registered on that edge.
  - The pointer is updated to winner+1, wrapping NREQ-1 to 0.
  - Requesters hold valid and operands until their ready; a request deasserted before its ready is simply not served.
- State machine, all transitions registered:
  - IDLE: no req_valid -> IDLE. Winner with divisor==0 -> RESP with quotient all-ones, remainder = dividend, err=1; the engine is untouched. Otherwise -> ISSUE.
  - ISSUE: div_start=1 for exactly one cycle -> WAIT.
  - WAIT: div_done=0 -> WAIT. div_done=1 -> capture div_quotient/div_remainder, err=0 -> CLEAR.
  - CLEAR: div_clr=1 for exactly one cycle -> RESP.
  - RESP: resp_valid=1 with resp_* stable. resp_ready=1 -> IDLE. Otherwise hold RESP.
- Latency, nonzero divisor: req_ready to resp_valid = (engine cycles from start to done) + 3. Divide-by-zero: resp_valid one cycle after req_ready.
- Throughput: one transaction at a time; a new grant occurs at the earliest on the cycle after the resp handshake.
- A div_done seen outside WAIT is ignored.
- Starvation bound: any held request is granted within NREQ transactions.

Optional Feature:
Macro DIV_SHARE_ARBITER_WDOG_EN.
- Defined:
  - A counter of ceil(log2(TMO+1)) bits clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TMO without div_done, the arbiter goes to CLEAR (div_clr pulse), then RESP with err=1, quotient=0, remainder=0.
- Undefined: WAIT waits indefinitely for div_done and no counter exists.

Test Plan:
- Single request: requester 2 sends 13/4; engine model asserts done 12 cycles after start -> resp_id=2, quotient=3, remainder=1, err=0; exactly one div_start and one div_clr pulse.
- Divide by zero: requester 0 sends 9/0 -> resp_valid one cycle after req_ready[0]; quotient=15, remainder=9, err=1; div_start never pulses.
- Round-robin: all four requesters valid continuously with distinct operands -> grant order 0,1,2,3,0; each resp_id matches that requester's quotient and remainder.
- Backpressure: resp_ready held low 5 cycles in RESP -> resp_* stable; no req_ready or div_start pulses until after the handshake.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT -> all outputs 0; div_clr pulses on the cycle after reset deasserts; next grant goes to requester 0.
- Watchdog (macro defined, TMO=64): engine never asserts done -> exactly 64 cycles in WAIT, then div_clr, then resp err=1, quotient=0, remainder=0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin front end sharing one iterative divider among
// NREQ requesters; each accepted request is started on the engine, its result
// collected and returned on a shared response bus tagged with the requester id.
// Divide-by-zero is answered locally without touching the engine.
// Optional watchdog on WAIT: define DIV_SHARE_ARBITER_WDOG_EN.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             per-requester handshake (ready is one-hot)
//   req_dividend/req_divisor        packed operands, requester i at [i*W +: W]
//   div_start/div_clr               one-cycle pulses to the engine
//   div_dividend/div_divisor        operands held from ISSUE through WAIT
//   div_done/div_quotient/div_remainder   engine status (level) and result
//   resp_valid/resp_ready           response handshake
//   resp_id/resp_quotient/resp_remainder/resp_err   response payload
//   busy                            high in every state except IDLE
module div_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2,
    parameter int TMO  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic              div_start,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    output logic              div_clr,
    input  logic              div_done,
    input  logic [W-1:0]      div_quotient,
    input  logic [W-1:0]      div_remainder,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_quotient,
    output logic [W-1:0]      resp_remainder,
    output logic              resp_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_err;
    logic           r_start;
    logic           r_clr;
    logic           r_rvalid;
    logic           r_busy;
    // Set while in reset; marks the first cycle after reset for the engine clear.
    logic           r_rst_d;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_sel;
    logic           w_grant;
    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [IDW-1:0] w_ptr_nxt;

`ifdef DIV_SHARE_ARBITER_WDOG_EN
    localparam int WDW = $clog2(TMO + 1);
    logic [WDW-1:0] r_wdog;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TMO;
`endif

    // Scan from the pointer downward in priority: the lowest offset wins,
    // so iterate from the highest offset and let later hits overwrite.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sel = IDW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_sel]) begin
                w_found = 1'b1;
                w_win   = w_sel;
            end
        end
    end

    // No grant during reset or on the post-reset engine-clear cycle.
    assign w_grant = w_found && (r_state == S_IDLE) && !r_rst_d && !reset;

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_win] = 1'b1;
    end

    assign w_a       = req_dividend[int'(w_win)*W +: W];
    assign w_b       = req_divisor[int'(w_win)*W +: W];
    assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_clr    <= 1'b0;
            r_rvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_rst_d  <= 1'b1;
`ifdef DIV_SHARE_ARBITER_WDOG_EN
            r_wdog   <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            r_clr   <= 1'b0;
            r_rst_d <= 1'b0;
            if (!r_rst_d) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_grant) begin
                            r_id   <= w_win;
                            r_ptr  <= w_ptr_nxt;
                            r_busy <= 1'b1;
                            if (w_b == '0) begin
                                r_q      <= '1;
                                r_r      <= w_a;
                                r_err    <= 1'b1;
                                r_rvalid <= 1'b1;
                                r_state  <= S_RESP;
                            end else begin
                                r_a     <= w_a;
                                r_b     <= w_b;
                                r_start <= 1'b1;
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_ISSUE: begin
`ifdef DIV_SHARE_ARBITER_WDOG_EN
                        r_wdog  <= '0;
`endif
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (div_done) begin
                            r_q     <= div_quotient;
                            r_r     <= div_remainder;
                            r_err   <= 1'b0;
                            r_clr   <= 1'b1;
                            r_state <= S_CLEAR;
                        end
`ifdef DIV_SHARE_ARBITER_WDOG_EN
                        else if (r_wdog == WDW'(TMO - 1)) begin
                            r_wdog  <= r_wdog + 1'b1;
                            r_q     <= '0;
                            r_r     <= '0;
                            r_err   <= 1'b1;
                            r_clr   <= 1'b1;
                            r_state <= S_CLEAR;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
`endif
                    end
                    S_CLEAR: begin
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end
                    S_RESP: begin
                        if (resp_ready) begin
                            r_rvalid <= 1'b0;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign div_start      = r_start;
    assign div_dividend   = r_a;
    assign div_divisor    = r_b;
    // Engine is forced back to init on the first cycle out of reset.
    assign div_clr        = r_clr | (r_rst_d & ~reset);
    assign resp_valid     = r_rvalid;
    assign resp_id        = r_id;
    assign resp_quotient  = r_q;
    assign resp_remainder = r_r;
    assign resp_err       = r_err;
    assign busy           = r_busy;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: self-checking bench for div_share_arbiter with an
// engine model and a round-robin reference model.
module tb_div_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_dividend = '0;
    logic [NREQ*W-1:0] req_divisor = '0;
    logic [NREQ-1:0]   req_ready;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_clr;
    logic              div_done = 1'b0;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_quotient;
    logic [W-1:0]      resp_remainder;
    logic              resp_err;
    logic              busy;

    int n_checks = 0;
    int n_fail = 0;
    int ptr_m = 0;
    int eng_d = 12;
    bit eng_hang = 1'b0;
    int eng_cnt = 0;
    int n_start = 0;
    int n_clr = 0;
    logic [W-1:0] eng_a = '0;
    logic [W-1:0] eng_b = '0;

    div_share_arbiter #(
        .NREQ(NREQ), .W(W), .IDW(IDW), .TMO(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_dividend(req_dividend),
        .req_divisor(req_divisor), .req_ready(req_ready),
        .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_clr(div_clr),
        .div_done(div_done), .div_quotient(div_quotient),
        .div_remainder(div_remainder),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_quotient(resp_quotient),
        .resp_remainder(resp_remainder), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Engine model: done rises eng_d cycles after the start pulse, holds until clr.
    always @(posedge clk) begin
        if (div_start === 1'b1) n_start++;
        if (div_clr === 1'b1) n_clr++;
        if (div_clr === 1'b1) begin
            div_done <= 1'b0;
            eng_cnt  <= 0;
        end else if (div_start === 1'b1) begin
            eng_a <= div_dividend;
            eng_b <= div_divisor;
            if (!eng_hang) begin
                if (eng_d <= 1) div_done <= 1'b1;
                else eng_cnt <= eng_d - 1;
            end
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) div_done <= 1'b1;
        end
    end

    assign div_quotient  = (eng_b == '0) ? '1 : eng_a / eng_b;
    assign div_remainder = (eng_b == '0) ? eng_a : eng_a % eng_b;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] outs();
        return {req_ready, div_start, div_dividend, div_divisor, resp_valid,
                resp_id, resp_quotient, resp_remainder, resp_err, busy, div_clr};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input int a, input int b);
        req_dividend[i*W +: W] = W'(a);
        req_divisor[i*W +: W]  = W'(b);
        req_valid[i] = 1'b1;
    endtask

    // One full transaction from grant to response handshake.
    task automatic serve(input int hold, input bit drop, input bit hang,
                         output int got);
        int win, k, lat, exp_lat, s0, c0, exp_s, exp_c, spur, unstable;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0] a, b, eq, er;
        logic ee;
        logic [IDW+2*W:0] snap;
        got = -1;
        #1;
        win = pick(req_valid);
        k = 0;
        while (req_ready === '0 && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (win < 0) begin
            n_fail++;
            $display("FAIL grant: no valid request, req_ready=%b", req_ready);
            return;
        end
        exp_rdy = '0;
        exp_rdy[win] = 1'b1;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
        end
        got = win;
        a = req_dividend[win*W +: W];
        b = req_divisor[win*W +: W];
        ptr_m = (win + 1) % NREQ;
        if (hang) begin
            eq = '0; er = '0; ee = 1'b1;
            exp_lat = TMO + 3; exp_s = 1; exp_c = 1;
        end else if (b == '0) begin
            eq = '1; er = a; ee = 1'b1;
            exp_lat = 1; exp_s = 0; exp_c = 0;
        end else begin
            eq = a / b; er = a % b; ee = 1'b0;
            exp_lat = eng_d + 3; exp_s = 1; exp_c = 1;
        end
        s0 = n_start;
        c0 = n_clr;
        tick();
        if (drop) req_valid[win] = 1'b0;
        #1;
        lat = 1;
        spur = 0;
        while (resp_valid !== 1'b1 && lat < 300) begin
            if (req_ready !== '0) spur++;
            tick();
            lat++;
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL latency: got %0d expected %0d", lat, exp_lat);
        end
        n_checks++;
        if (resp_id !== IDW'(win)) begin
            n_fail++;
            $display("FAIL resp_id: got %0d expected %0d", resp_id, win);
        end
        n_checks++;
        if (resp_quotient !== eq) begin
            n_fail++;
            $display("FAIL quotient: got %0d expected %0d", resp_quotient, eq);
        end
        n_checks++;
        if (resp_remainder !== er) begin
            n_fail++;
            $display("FAIL remainder: got %0d expected %0d", resp_remainder, er);
        end
        n_checks++;
        if (resp_err !== ee) begin
            n_fail++;
            $display("FAIL err: got %b expected %b", resp_err, ee);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_resp: got %b expected 1", busy);
        end
        n_checks++;
        if (n_start - s0 != exp_s) begin
            n_fail++;
            $display("FAIL start_pulses: got %0d expected %0d", n_start - s0, exp_s);
        end
        n_checks++;
        if (n_clr - c0 != exp_c) begin
            n_fail++;
            $display("FAIL clr_pulses: got %0d expected %0d", n_clr - c0, exp_c);
        end
        snap = {resp_id, resp_quotient, resp_remainder, resp_err};
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (resp_valid !== 1'b1) unstable++;
            if ({resp_id, resp_quotient, resp_remainder, resp_err} !== snap)
                unstable++;
            if (req_ready !== '0 || n_start - s0 != exp_s) spur++;
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++;
            $display("FAIL resp_stable: got %0d changes expected 0", unstable);
        end
        n_checks++;
        if (spur != 0) begin
            n_fail++;
            $display("FAIL spurious_pulse: got %0d expected 0", spur);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1;
        n_checks++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL after_handshake: valid,busy=%b expected 00", {resp_valid, busy});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ptr_m = 0;
        tick();
    endtask

    task automatic test_reset();
        req_valid = '0;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %h expected 0", outs());
        end
        set_req(2, 13, 4);
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 27'd1) begin
            n_fail++;
            $display("FAIL post_reset_clr: got %h expected 1", outs());
        end
        tick();
        n_checks++;
        if ({div_clr, req_ready} !== 5'b00100) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b expected 00100", {div_clr, req_ready});
        end
        ptr_m = 0;
    endtask

    task automatic test_single();
        int got;
        req_valid = '0;
        set_req(2, 13, 4);
        eng_d = 12;
        serve(0, 1'b1, 1'b0, got);
        n_checks++;
        if (got != 2) begin
            n_fail++;
            $display("FAIL single_id: got %0d expected 2", got);
        end
    endtask

    task automatic test_div_zero();
        int got;
        set_req(0, 9, 0);
        serve(0, 1'b1, 1'b0, got);
    endtask

    task automatic test_backpressure();
        int got;
        set_req(1, 14, 3);
        eng_d = 4;
        serve(5, 1'b1, 1'b0, got);
    endtask

    task automatic test_round_robin();
        int got;
        req_valid = '0;
        apply_reset();
        set_req(0, 15, 2);
        set_req(1, 9, 4);
        set_req(2, 12, 5);
        set_req(3, 11, 3);
        eng_d = 3;
        for (int i = 0; i < 5; i++) begin
            serve(0, 1'b0, 1'b0, got);
            n_checks++;
            if (got != i % NREQ) begin
                n_fail++;
                $display("FAIL rr_order: got %0d expected %0d", got, i % NREQ);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_wait();
        int got, k;
        req_valid = '0;
        set_req(1, 7, 2);
        eng_d = 40;
        #1;
        k = 0;
        while (req_ready === '0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        tick();
        tick();
        set_req(0, 11, 3);
        reset = 1'b1;
        tick();
        n_checks++;
        if (outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_wait_outs: got %h expected 0", outs());
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 27'd1) begin
            n_fail++;
            $display("FAIL reset_wait_clr: got %h expected 1", outs());
        end
        tick();
        n_checks++;
        if (div_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_clr_once: got %b expected 0", div_clr);
        end
        ptr_m = 0;
        eng_d = 5;
        serve(0, 1'b1, 1'b0, got);
        n_checks++;
        if (got != 0) begin
            n_fail++;
            $display("FAIL reset_wait_next: got %0d expected 0", got);
        end
    endtask

    task automatic test_random();
        int got;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, 15)),
                            ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15)));
            end
            if (req_valid == '0)
                set_req(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            eng_d = int'($urandom_range(1, 20));
            serve(int'($urandom_range(0, 3)), 1'b1, 1'b0, got);
        end
        req_valid = '0;
    endtask

`ifdef DIV_SHARE_ARBITER_WDOG_EN
    task automatic test_watchdog();
        int got;
        req_valid = '0;
        set_req(3, 5, 1);
        eng_hang = 1'b1;
        serve(0, 1'b1, 1'b1, got);
        eng_hang = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_div_zero();
        test_backpressure();
        test_round_robin();
        test_reset_wait();
        test_random();
`ifdef DIV_SHARE_ARBITER_WDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
